// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter that shares one async-FIFO write port
// among NREQ producers in the write clock domain.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     winc,
  output logic [DW-1:0]            wdata,
  input  logic                     wfull,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [15:0]              stall_cnt
);

  localparam int IDW = $clog2(NREQ);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]    stall_cnt_q, stall_cnt_d;

  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic [IDW-1:0] next_ptr;
  logic           owner_valid;
  logic [DW-1:0]  owner_data;

  // Scan offsets from the highest down so the smallest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        pick     = IDW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id_q) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DW +: DW];
      end
    end
    next_ptr = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    winc        = 1'b0;
    req_ready   = '0;
    wdata       = '0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = GRANT;
          grant_id_d = pick;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        busy                  = 1'b1;
        wdata                 = owner_data;
        req_ready[grant_id_q] = ~wfull;
        winc                  = owner_valid & ~wfull;
        // A full FIFO freezes the grant; only stalled-but-valid cycles are counted.
        if (wfull) begin
          if (owner_valid && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        end else if (owner_valid) begin
          if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            state_d    = IDLE;
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else begin
          state_d    = IDLE;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!wrst_n) begin
      winc      = 1'b0;
      req_ready = '0;
      wdata     = '0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_id  = grant_id_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: producers hold words until accepted and a
// transaction-level model predicts every output each cycle.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic                wclk = 1'b0;
  logic                wrst_n = 1'b0;
  logic                wfull = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic                winc;
  logic [DW-1:0]       wdata;
  logic [1:0]          grant_id;
  logic                busy;
  logic [15:0]         stall_cnt;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .winc(winc), .wdata(wdata), .wfull(wfull),
    .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 wclk = ~wclk;

  // Model: owner < 0 means nobody holds the write port.
  int m_owner = -1;
  int m_rr    = 0;
  int m_beats = 0;
  int m_gid   = 0;
  int m_stall = 0;

  bit          pend[NREQ];
  logic [DW-1:0] pdata[NREQ];
  int          words_left[NREQ];

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic applyStimulus(input int n, input int gen_prob, input int full_prob, input int rst_prob);
    logic [NREQ-1:0] e_ready;
    logic            e_winc;
    logic            e_busy;
    logic [DW-1:0]   e_wdata;
    for (int c = 0; c < n; c++) begin
      @(negedge wclk);
      wrst_n = !(int'($urandom_range(99)) < rst_prob);
      wfull  = (int'($urandom_range(99)) < full_prob);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && words_left[i] > 0 && int'($urandom_range(99)) < gen_prob) begin
          pend[i]  = 1'b1;
          pdata[i] = DW'($urandom);
          words_left[i]--;
        end
        req_valid[i]          = pend[i];
        req_data[i*DW +: DW]  = pdata[i];
      end
      #1;
      e_ready = '0;
      e_winc  = 1'b0;
      e_busy  = 1'b0;
      e_wdata = '0;
      if (wrst_n && m_owner >= 0) begin
        e_busy           = 1'b1;
        e_wdata          = pdata[m_owner];
        e_ready[m_owner] = !wfull;
        e_winc           = pend[m_owner] && !wfull;
      end
      checkOutput("winc", 32'(winc), 32'(e_winc));
      checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
      checkOutput("wdata", 32'(wdata), 32'(e_wdata));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));

      @(posedge wclk);
      if (!wrst_n) begin
        m_owner = -1; m_rr = 0; m_beats = 0; m_gid = 0; m_stall = 0;
      end else if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_rr + k) % NREQ;
          if (pend[idx] && m_owner < 0) m_owner = idx;
        end
        if (m_owner >= 0) begin
          m_gid   = m_owner;
          m_beats = 0;
        end
      end else if (wfull) begin
        if (pend[m_owner] && m_stall < 65535) m_stall++;
      end else if (pend[m_owner]) begin
        pend[m_owner] = 1'b0;
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_rr    = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end else begin
        m_rr    = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; pdata[i] = '0; words_left[i] = 1000;
    end
    @(posedge wclk);

    // Everyone valid while held in reset.
    applyStimulus(3, 100, 0, 100);

    // Requester 2 alone with six words: two bursts split by one bubble.
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; words_left[i] = 0;
    end
    words_left[2] = 6;
    applyStimulus(12, 100, 0, 0);

    for (int i = 0; i < NREQ; i++) words_left[i] = 100000;
    applyStimulus(20, 100, 0, 0);

    // FIFO full for five cycles in the middle of a burst.
    applyStimulus(2, 100, 0, 0);
    applyStimulus(5, 100, 100, 0);
    applyStimulus(10, 100, 0, 0);

    // One-cycle reset pulse mid-burst.
    applyStimulus(1, 100, 0, 100);
    applyStimulus(8, 100, 0, 0);

    applyStimulus(3000, 40, 20, 1);
    applyStimulus(1000, 90, 5, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
